// File: rtl/dmac_pkg.sv
// ---------------------------------------------------------------------------
// dmac_pkg
// Shared definitions for the DMA channel arbiter slice.
//   DMAC_NUM_CH          default number of channels sharing the AHB master
//   DMAC_TIMEOUT_CYCLES  default grant hold limit (timeout build only)
//   arb_state_t          arbiter FSM state encoding
// ---------------------------------------------------------------------------
package dmac_pkg;

    localparam int unsigned DMAC_NUM_CH         = 4;
    localparam int unsigned DMAC_TIMEOUT_CYCLES = 1024;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_GRANT   = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

endpackage

// File: rtl/dmac_rr_picker.sv
// ---------------------------------------------------------------------------
// dmac_rr_picker
// Combinational rotating-priority encoder. The search starts at rr_ptr and
// wraps modulo NUM_CH; the first pending channel found wins.
// Ports:
//   pending [NUM_CH]   channels currently requesting and enabled
//   rr_ptr  [IW]       channel holding highest priority this round
//   winner  [IW]       selected channel index (0 when nothing is pending)
//   valid   [1]        at least one channel is pending
// ---------------------------------------------------------------------------
module dmac_rr_picker
    import dmac_pkg::*;
#(
    parameter  int unsigned NUM_CH = DMAC_NUM_CH,
    localparam int unsigned IW     = $clog2(NUM_CH)
) (
    input  logic [NUM_CH-1:0] pending,
    input  logic [IW-1:0]     rr_ptr,
    output logic [IW-1:0]     winner,
    output logic              valid
);

    always_comb begin
        int unsigned idx;
        idx    = 0;
        winner = '0;
        valid  = 1'b0;
        for (int unsigned i = 0; i < NUM_CH; i++) begin
            // rr_ptr < NUM_CH, so a single subtraction implements the wrap
            idx = 32'(rr_ptr) + i;
            if (idx >= NUM_CH) begin
                idx = idx - NUM_CH;
            end
            if (!valid && pending[IW'(idx)]) begin
                valid  = 1'b1;
                winner = IW'(idx);
            end
        end
    end

endmodule

// File: rtl/dmac_ch_arbiter.sv
// ---------------------------------------------------------------------------
// dmac_ch_arbiter
// Round-robin arbiter granting one DMA channel at a time ownership of the
// shared AHB master port. IDLE picks a winner, GRANT holds it until the
// channel completes (or is disabled), RELEASE waits for the bus to go idle.
//
// Build option:
//   DMAC_ARB_TIMEOUT_EN  when defined, a grant held for TIMEOUT_CYCLES
//                        cycles without ch_done is revoked and timeout_err
//                        pulses. When undefined the grant is held
//                        indefinitely and timeout_err is tied low.
//
// Ports:
//   clk          system clock, rising edge
//   rst          asynchronous active-high reset
//   ch_req       per-channel peripheral request (level)
//   ch_en        per-channel enable from configuration registers
//   ch_done      per-channel completion pulse
//   bus_idle     master port idle (HTRANS IDLE and HREADY high)
//   ch_grant     one-hot port ownership
//   ch_start     one-cycle pulse on the first grant cycle
//   ch_ack       one-cycle pulse on normal completion of the owner
//   grant_id     index of the owner, 0 when nothing is granted
//   busy         arbiter is not idle
//   timeout_err  one-cycle pulse when a grant times out
// ---------------------------------------------------------------------------
module dmac_ch_arbiter
    import dmac_pkg::*;
#(
    parameter  int unsigned NUM_CH         = DMAC_NUM_CH,
    parameter  int unsigned TIMEOUT_CYCLES = DMAC_TIMEOUT_CYCLES,
    localparam int unsigned IW             = $clog2(NUM_CH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NUM_CH-1:0] ch_req,
    input  logic [NUM_CH-1:0] ch_en,
    input  logic [NUM_CH-1:0] ch_done,
    input  logic              bus_idle,
    output logic [NUM_CH-1:0] ch_grant,
    output logic [NUM_CH-1:0] ch_start,
    output logic [NUM_CH-1:0] ch_ack,
    output logic [IW-1:0]     grant_id,
    output logic              busy,
    output logic              timeout_err
);

    arb_state_t        state, state_nxt;
    logic [IW-1:0]     owner, owner_nxt;
    logic [IW-1:0]     rr_ptr, rr_ptr_nxt;
    logic              first, first_nxt;
    logic [NUM_CH-1:0] pending;
    logic [IW-1:0]     pick_winner;
    logic              pick_valid;

`ifdef DMAC_ARB_TIMEOUT_EN
    localparam int unsigned CW = $clog2(TIMEOUT_CYCLES);
    logic [CW-1:0] tmo_cnt, tmo_cnt_nxt;
`else
    // keeps TIMEOUT_CYCLES referenced while the counter is compiled out
    logic unused_timeout_cfg;
    assign unused_timeout_cfg = (TIMEOUT_CYCLES != 0);
`endif

    assign pending = ch_req & ch_en;

    dmac_rr_picker #(
        .NUM_CH (NUM_CH)
    ) u_picker (
        .pending (pending),
        .rr_ptr  (rr_ptr),
        .winner  (pick_winner),
        .valid   (pick_valid)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= ARB_IDLE;
            owner   <= '0;
            rr_ptr  <= '0;
            first   <= 1'b0;
`ifdef DMAC_ARB_TIMEOUT_EN
            tmo_cnt <= '0;
`endif
        end else begin
            state   <= state_nxt;
            owner   <= owner_nxt;
            rr_ptr  <= rr_ptr_nxt;
            first   <= first_nxt;
`ifdef DMAC_ARB_TIMEOUT_EN
            tmo_cnt <= tmo_cnt_nxt;
`endif
        end
    end

    always_comb begin
        state_nxt   = state;
        owner_nxt   = owner;
        rr_ptr_nxt  = rr_ptr;
        first_nxt   = 1'b0;
        ch_grant    = '0;
        ch_start    = '0;
        ch_ack      = '0;
        grant_id    = '0;
        busy        = (state != ARB_IDLE);
        timeout_err = 1'b0;
`ifdef DMAC_ARB_TIMEOUT_EN
        // counter only advances in GRANT, so it is 0 on every first grant cycle
        tmo_cnt_nxt = '0;
`endif

        case (state)
            ARB_IDLE: begin
                if (pick_valid) begin
                    state_nxt  = ARB_GRANT;
                    owner_nxt  = pick_winner;
                    first_nxt  = 1'b1;
                    // winner drops to lowest priority for the next round
                    rr_ptr_nxt = (pick_winner == IW'(NUM_CH - 1)) ? '0 : pick_winner + 1'b1;
                end
            end

            ARB_GRANT: begin
                ch_grant[owner] = 1'b1;
                ch_start[owner] = first;
                grant_id        = owner;
                // completion outranks abort, abort outranks timeout
                if (ch_done[owner]) begin
                    ch_ack[owner] = 1'b1;
                    state_nxt     = ARB_RELEASE;
                end else if (!ch_en[owner]) begin
                    state_nxt = ARB_RELEASE;
                end
`ifdef DMAC_ARB_TIMEOUT_EN
                else if (tmo_cnt == CW'(TIMEOUT_CYCLES - 1)) begin
                    timeout_err = 1'b1;
                    state_nxt   = ARB_RELEASE;
                end else begin
                    tmo_cnt_nxt = tmo_cnt + 1'b1;
                end
`endif
            end

            ARB_RELEASE: begin
                if (bus_idle) begin
                    state_nxt = ARB_IDLE;
                end
            end

            default: begin
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule
